// File: rtl/myipwrapper_regbank_axil_if.sv
// AXI4-Lite bus bundle for the wrapper register bank; slave modport faces the
// register bank, master modport faces the interconnect side.
interface myipwrapper_regbank_axil_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 6
);
  logic [AddrWidth-1:0]     awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [DataWidth-1:0]     wdata;
  logic [DataWidth/8-1:0]   wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  logic [AddrWidth-1:0]     araddr;
  logic                     arvalid;
  logic                     arready;
  logic [DataWidth-1:0]     rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/myipwrapper_regbank_axil.sv
// AXI4-Lite register bank: read-only ID at word 0, R/W control words above it.
// Define MYIPWRAPPER_REGBANK_WR_PULSE_EN to generate the per-word write strobes.
module myipwrapper_regbank_axil #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_NUM_REGS         = 8,
  parameter logic [31:0] C_ID_VALUE         = 32'h12345678
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  myipwrapper_regbank_axil_if.slave                s_axi,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                    reg_wr_pulse
);
  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned AddrLsb = $clog2(SW);
  localparam int unsigned IdxW    = C_S_AXI_ADDR_WIDTH - AddrLsb;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic            aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [IdxW-1:0] aw_idx_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   regs_q [1:C_NUM_REGS-1];
  logic [DW-1:0]   regs_d [1:C_NUM_REGS-1];

  logic            aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [DW-1:0]   wr_data, rd_data;
  logic [SW-1:0]   wr_strb;
  logic [1:0]      rd_resp;

  assign s_axi.awready = !aw_held_q && !bvalid_q;
  assign s_axi.wready  = !w_held_q && !bvalid_q;
  assign s_axi.arready = !rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // Held copies take priority; otherwise use whatever is handshaking this cycle.
  assign wr_idx  = aw_held_q ? aw_idx_q : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
  assign wr_data = w_held_q ? wdata_q : s_axi.wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axi.wstrb;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_ok   = (wr_idx != '0) && (32'(wr_idx) < C_NUM_REGS);
  assign rd_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi.awaddr[AddrLsb-1:0], s_axi.araddr[AddrLsb-1:0]};

  always_comb begin
    regs_d = regs_q;
    if (commit && wr_ok) begin
      for (int unsigned k = 1; k < C_NUM_REGS; k++) begin
        if (32'(wr_idx) == k) begin
          for (int unsigned b = 0; b < SW; b++) begin
            if (wr_strb[b]) regs_d[k][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespSlvErr;
    if (rd_idx == '0) begin
      rd_data = DW'(C_ID_VALUE);
      rd_resp = RespOkay;
    end else begin
      for (int unsigned k = 1; k < C_NUM_REGS; k++) begin
        if (32'(rd_idx) == k) begin
          rd_data = regs_q[k];
          rd_resp = RespOkay;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      regs_q    <= '{default: '0};
    end else begin
      regs_q <= regs_d;
      if (aw_hs) aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RespOkay : RespSlvErr;
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs)  w_held_q  <= 1'b1;
        if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    reg_out[0 +: DW] = DW'(C_ID_VALUE);
    for (int unsigned k = 1; k < C_NUM_REGS; k++) begin
      reg_out[k*DW +: DW] = regs_q[k];
    end
  end

`ifdef MYIPWRAPPER_REGBANK_WR_PULSE_EN
  logic [C_NUM_REGS-1:0] wr_pulse_d, wr_pulse_q;

  always_comb begin
    wr_pulse_d = '0;
    if (commit && wr_ok) begin
      for (int unsigned k = 1; k < C_NUM_REGS; k++) begin
        if (32'(wr_idx) == k) wr_pulse_d[k] = |wr_strb;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) wr_pulse_q <= '0;
    else              wr_pulse_q <= wr_pulse_d;
  end

  assign reg_wr_pulse = wr_pulse_q;
`else
  assign reg_wr_pulse = '0;
`endif
endmodule
